// File: rtl/regfile_port_ctrl_pkg.sv
// Shared definitions for the register-file port controller: default widths,
// FSM state encoding and the number of registers zeroed by a clear sweep.
package regfile_port_ctrl_pkg;

  localparam int DW_DEFAULT  = 16;
  localparam int AW_DEFAULT  = 3;
  localparam int WBQ_DEFAULT = 4;
  localparam int CLEAR_COUNT = 8;
  localparam int CLR_W       = $clog2(CLEAR_COUNT);

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/regfile_wb_fifo.sv
// Writeback FIFO: in-order queue of pending register writes, plus a
// youngest-match search used to forward operands ahead of the register file.
module regfile_wb_fifo
  import regfile_port_ctrl_pkg::*;
#(
  parameter int DW    = DW_DEFAULT,
  parameter int AW    = AW_DEFAULT,
  parameter int DEPTH = WBQ_DEFAULT
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          i_push,
  input  logic [AW-1:0] i_pushAddr,
  input  logic [DW-1:0] i_pushData,
  input  logic          i_pop,
  input  logic [AW-1:0] i_lookAddr1,
  input  logic [AW-1:0] i_lookAddr2,
  output logic          o_empty,
  output logic          o_full,
  output logic [AW-1:0] o_headAddr,
  output logic [DW-1:0] o_headData,
  output logic          o_hit1,
  output logic          o_hit2,
  output logic [DW-1:0] o_fwd1,
  output logic [DW-1:0] o_fwd2
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [AW-1:0] r_addr [DEPTH];
  logic [DW-1:0] r_data [DEPTH];
  logic [PW-1:0] r_rdPtr;
  logic [PW-1:0] r_wrPtr;
  logic [CW-1:0] r_count;
  logic [PW-1:0] w_rdNext;
  logic [PW-1:0] w_wrNext;

  function automatic logic [PW-1:0] slotOf(input logic [PW-1:0] base, input int offset);
    int s;
    s = int'(base) + offset;
    if (s >= DEPTH) s = s - DEPTH;
    return PW'(s);
  endfunction

  assign w_rdNext   = (r_rdPtr == PW'(DEPTH - 1)) ? '0 : r_rdPtr + PW'(1);
  assign w_wrNext   = (r_wrPtr == PW'(DEPTH - 1)) ? '0 : r_wrPtr + PW'(1);
  assign o_empty    = (r_count == '0);
  assign o_full     = (r_count == CW'(DEPTH));
  assign o_headAddr = r_addr[r_rdPtr];
  assign o_headData = r_data[r_rdPtr];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rdPtr <= '0;
      r_wrPtr <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wrPtr <= w_wrNext;
      if (i_pop) r_rdPtr <= w_rdNext;
      if (i_push && !i_pop) r_count <= r_count + CW'(1);
      else if (!i_push && i_pop) r_count <= r_count - CW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (i_push) begin
      r_addr[r_wrPtr] <= i_pushAddr;
      r_data[r_wrPtr] <= i_pushData;
    end
  end

  // Walk oldest to youngest so later matches win; a same-cycle push beats all.
  always_comb begin
    o_hit1 = 1'b0;
    o_hit2 = 1'b0;
    o_fwd1 = '0;
    o_fwd2 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (i < int'(r_count)) begin
        if (r_addr[slotOf(r_rdPtr, i)] == i_lookAddr1) begin
          o_hit1 = 1'b1;
          o_fwd1 = r_data[slotOf(r_rdPtr, i)];
        end
        if (r_addr[slotOf(r_rdPtr, i)] == i_lookAddr2) begin
          o_hit2 = 1'b1;
          o_fwd2 = r_data[slotOf(r_rdPtr, i)];
        end
      end
    end
    if (i_push && (i_pushAddr == i_lookAddr1)) begin
      o_hit1 = 1'b1;
      o_fwd1 = i_pushData;
    end
    if (i_push && (i_pushAddr == i_lookAddr2)) begin
      o_hit2 = 1'b1;
      o_fwd2 = i_pushData;
    end
  end

endmodule

// File: rtl/regfile_port_ctrl.sv
// Register-file port controller: serves two-operand reads with forwarding from
// a writeback queue, drains that queue into the register file and sweeps it to zero.
module regfile_port_ctrl
  import regfile_port_ctrl_pkg::*;
#(
  parameter int DW  = DW_DEFAULT,
  parameter int AW  = AW_DEFAULT,
  parameter int WBQ = WBQ_DEFAULT
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          rq_valid,
  output logic          rq_ready,
  input  logic [AW-1:0] rq_src1,
  input  logic [AW-1:0] rq_src2,
  output logic          op_valid,
  input  logic          op_ready,
  output logic [DW-1:0] op_data1,
  output logic [DW-1:0] op_data2,
  input  logic          wb_valid,
  output logic          wb_ready,
  input  logic [AW-1:0] wb_addr,
  input  logic [DW-1:0] wb_data,
  input  logic          clear_req,
  output logic          busy,
  output logic [AW-1:0] address1,
  output logic [AW-1:0] address2,
  output logic [AW-1:0] writeAddress,
  output logic [DW-1:0] writeData,
  output logic          write,
  input  logic [DW-1:0] data1,
  input  logic [DW-1:0] data2
);

  state_e           r_state;
  state_e           w_nextState;
  logic [CLR_W-1:0] r_clrIdx;
  logic             w_clrLast;
  logic             r_opValid;
  logic [DW-1:0]    r_opData1;
  logic [DW-1:0]    r_opData2;
  logic             w_inRun;
  logic             w_pop;
  logic             w_push;
  logic             w_rqFire;
  logic             w_fifoEmpty;
  logic             w_fifoFull;
  logic [AW-1:0]    w_headAddr;
  logic [DW-1:0]    w_headData;
  logic             w_hit1;
  logic             w_hit2;
  logic [DW-1:0]    w_fwd1;
  logic [DW-1:0]    w_fwd2;

  assign address1  = rq_src1;
  assign address2  = rq_src2;
  assign op_valid  = r_opValid;
  assign op_data1  = r_opData1;
  assign op_data2  = r_opData2;
  assign w_clrLast = (r_clrIdx == CLR_W'(CLEAR_COUNT - 1));
  assign w_push    = wb_valid && wb_ready;
  assign w_rqFire  = rq_valid && rq_ready;

  regfile_wb_fifo #(.DW(DW), .AW(AW), .DEPTH(WBQ)) u_wbFifo (
    .clock       (clock),
    .reset       (reset),
    .i_push      (w_push),
    .i_pushAddr  (wb_addr),
    .i_pushData  (wb_data),
    .i_pop       (w_pop),
    .i_lookAddr1 (rq_src1),
    .i_lookAddr2 (rq_src2),
    .o_empty     (w_fifoEmpty),
    .o_full      (w_fifoFull),
    .o_headAddr  (w_headAddr),
    .o_headData  (w_headData),
    .o_hit1      (w_hit1),
    .o_hit2      (w_hit2),
    .o_fwd1      (w_fwd1),
    .o_fwd2      (w_fwd2)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= ST_CLEAR;
    else        r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_CLEAR: if (w_clrLast) w_nextState = ST_RUN;
      ST_RUN:   if (clear_req) w_nextState = ST_DRAIN;
      ST_DRAIN: if (w_fifoEmpty) w_nextState = ST_CLEAR;
      default:  w_nextState = ST_CLEAR;
    endcase
  end

  // Write port is gated by reset so it drops the instant reset asserts.
  always_comb begin
    w_inRun      = reset && (r_state == ST_RUN);
    w_pop        = reset && (r_state != ST_CLEAR) && !w_fifoEmpty;
    rq_ready     = w_inRun && (!r_opValid || op_ready);
    wb_ready     = w_inRun && (!w_fifoFull || w_pop);
    busy         = (r_state != ST_RUN);
    write        = 1'b0;
    writeAddress = '0;
    writeData    = '0;
    if (reset) begin
      if (r_state == ST_CLEAR) begin
        write        = 1'b1;
        writeAddress = AW'(r_clrIdx);
      end else if (!w_fifoEmpty) begin
        write        = 1'b1;
        writeAddress = w_headAddr;
        writeData    = w_headData;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_clrIdx <= '0;
    else if ((r_state == ST_CLEAR) && !w_clrLast) r_clrIdx <= r_clrIdx + CLR_W'(1);
    else r_clrIdx <= '0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_opValid <= 1'b0;
      r_opData1 <= '0;
      r_opData2 <= '0;
    end else if (w_rqFire) begin
      r_opValid <= 1'b1;
      r_opData1 <= w_hit1 ? w_fwd1 : data1;
      r_opData2 <= w_hit2 ? w_fwd2 : data2;
    end else if (op_ready) begin
      r_opValid <= 1'b0;
    end
  end

endmodule

// File: doc/regfile_port_ctrl.md
REGFILE_PORT_CTRL -- requirements
Module: regfile_port_ctrl

Interface
REQ-001 Parameters SHALL be: DW, default 16, data width; AW, default 3, register address width; WBQ, default 4, writeback FIFO depth.
REQ-002 Port clock  in  1  the only clock, rising edge.
REQ-003 Port reset  in  1  asynchronous, active-low reset.
REQ-004 Port rq_valid/rq_ready  in/out  1/1  operand-read request handshake.
REQ-005 Port rq_src1, rq_src2  in  AW each  source register addresses.
REQ-006 Port op_valid/op_ready  out/in  1/1  operand-result handshake.
REQ-007 Port op_data1, op_data2  out  DW each  operands.
REQ-008 Port wb_valid/wb_ready  in/out  1/1  writeback request handshake.
REQ-009 Port wb_addr, wb_data  in  AW/DW  writeback destination and value.
REQ-010 Port clear_req  in  1  request to zero all registers.
REQ-011 Port busy  out  1  high in DRAIN or CLEAR.
REQ-012 Ports address1, address2, writeAddress  out  AW each, and writeData  out  DW: drive the Register read and write ports.
REQ-013 Port write  out  1  Register write enable; data1, data2  in  DW each: combinational Register read data.

Function
REQ-014 FSM states SHALL be CLEAR, RUN and DRAIN; after reset the state SHALL be CLEAR.
REQ-015 CLEAR: write=1, writeData=0, writeAddress=0..7 on 8 consecutive cycles, then RUN; rq_ready=0, wb_ready=0.
REQ-016 RUN: clear_req=1 -> DRAIN; DRAIN with FIFO empty -> CLEAR; DRAIN: rq_ready=0, wb_ready=0, FIFO keeps draining.
REQ-017 Read: address1=rq_src1, address2=rq_src2 combinationally; accept when rq_valid and rq_ready in RUN.
REQ-018 Accepted request in cycle N SHALL present op_valid=1 with operands from cycle N in cycle N+1, a latency of 1.
REQ-019 op_valid/op_data SHALL hold stable until op_ready=1; rq_ready = RUN and (!op_valid or op_ready).
REQ-020 Forwarding priority per operand SHALL be: write accepted the same cycle with matching address, then youngest matching FIFO entry, then the FIFO head being written, then dataN.
REQ-021 Writeback FIFO: wb_ready = RUN and not full, or RUN and full with a drain the same cycle.
REQ-022 In RUN/DRAIN with FIFO non-empty, each cycle: write=1, writeAddress/writeData = head, pop.
REQ-023 Simultaneous push and pop SHALL keep the count; pointers SHALL wrap modulo WBQ; pushes to the same address SHALL be written in order.
REQ-024 With FIFO empty outside CLEAR, write=0.
REQ-025 clear_req outside RUN SHALL be ignored.
REQ-026 A pending op_valid at DRAIN entry SHALL be held until op_ready; no new request is accepted.

Reset
REQ-027 reset=0 SHALL immediately force: state CLEAR with clear index 0, FIFO empty, op_valid=0, op_data1/2=0, write=0, writeAddress=0, writeData=0, rq_ready=0, wb_ready=0, busy=1.
REQ-028 Reset asserted mid-CLEAR or mid-DRAIN SHALL abort and restart CLEAR from address 0 after release; queued writebacks SHALL be discarded.
REQ-029 First write SHALL occur on the first rising edge after release.

Structure
REQ-030 A shared package SHALL hold DW and AW defaults, the FSM state encoding and the clear-count constant 8.
REQ-031 The FIFO with its address-match/forward search SHALL be one sub-module, regfile_wb_fifo.

Verification
REQ-032 After reset release, check write=1 with writeAddress 0..7, writeData=0 for 8 cycles, then busy=0 and rq_ready=1.
REQ-033 Push wb (3, 0x0008), then request src1=3 and src2=5 the same cycle -> next cycle op_data1=0x0008 (forwarded), op_data2=Register r5.
REQ-034 Push 4 writebacks back-to-back to addresses 1,2,1,4 with wb_ready held low for one cycle while full -> Register r1 ends with the third value and order is preserved.
REQ-035 Hold op_ready=0 for 3 cycles after request -> op_valid and op_data stable, rq_ready=0 throughout.
REQ-036 clear_req with 2 writebacks queued -> DRAIN writes 2 entries, then CLEAR writes zeros to 0..7, busy high across the sequence.
REQ-037 Assert reset at CLEAR index 4 -> outputs zero immediately; after release CLEAR restarts at address 0.
